// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide unit for the E stage.
// Fixed-latency sequencing, HI/LO commit, and MTHI/MTLO service.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        hilo_we,
  input  logic        hilo_sel,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned MAXC =
    (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic [31:0]   hi_q;
  logic [31:0]   lo_q;
  logic [1:0]    op_q;
  logic [31:0]   a_q;
  logic [31:0]   b_q;

  logic [31:0]   hi_d;
  logic [31:0]   lo_d;
  logic          wr_d;

  logic [63:0]   prod_s;
  logic [63:0]   prod_u;
  logic [31:0]   abs_a;
  logic [31:0]   abs_b;
  logic [31:0]   dvs_u;
  logic [31:0]   dvs_s;
  logic [31:0]   uq;
  logic [31:0]   ur;
  logic [31:0]   sq;
  logic [31:0]   sr;

  // Result datapath, evaluated from the latched operands.
  // Signed divide works on magnitudes so MIN/-1 wraps cleanly.
  always_comb begin
    prod_s = $signed({{32{a_q[31]}}, a_q})
           * $signed({{32{b_q[31]}}, b_q});
    prod_u = {32'b0, a_q} * {32'b0, b_q};
    abs_a  = a_q[31] ? (~a_q + 32'd1) : a_q;
    abs_b  = b_q[31] ? (~b_q + 32'd1) : b_q;
    dvs_u  = (b_q == 32'd0) ? 32'd1 : b_q;
    dvs_s  = (b_q == 32'd0) ? 32'd1 : abs_b;
    uq     = a_q / dvs_u;
    ur     = a_q % dvs_u;
    sq     = abs_a / dvs_s;
    sr     = abs_a % dvs_s;
    if (a_q[31] ^ b_q[31]) sq = ~sq + 32'd1;
    if (a_q[31]) sr = ~sr + 32'd1;
    hi_d = 32'd0;
    lo_d = 32'd0;
    wr_d = 1'b1;
    case (op_q)
      2'b00: begin hi_d = prod_s[63:32]; lo_d = prod_s[31:0]; end
      2'b01: begin hi_d = prod_u[63:32]; lo_d = prod_u[31:0]; end
      2'b10: begin hi_d = sr; lo_d = sq; end
      default: begin hi_d = ur; lo_d = uq; end
    endcase
    if (op_q[1] && (b_q == 32'd0)) wr_d = 1'b0;
  end

  // Sequencer: accept, count down, commit HI/LO as busy drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      op_q    <= 2'b00;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q    <= md_op;
            a_q     <= A;
            b_q     <= B;
            cnt_q   <= md_op[1] ? CW'(DIV_CYCLES)
                                : CW'(MULT_CYCLES);
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else if (hilo_we) begin
            if (hilo_sel) hi_q <= wdata;
            else          lo_q <= wdata;
          end
        end
        RUN: begin
          if (cnt_q == CW'(1)) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            if (wr_d) begin
              hi_q <= hi_d;
              lo_q <= lo_d;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign stall_req = start | busy_q;
  assign HI        = hi_q;
  assign LO        = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Directed bench for mdu_ctrl.
// Each scenario task drives and checks its own vectors.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  md_op = 2'b00;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        hilo_we = 1'b0;
  logic        hilo_sel = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic        busy;
  logic        stall_req;
  logic [31:0] HI;
  logic [31:0] LO;

  int total = 0;
  int bad = 0;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .A(A), .B(B), .hilo_we(hilo_we), .hilo_sel(hilo_sel),
    .wdata(wdata), .busy(busy), .stall_req(stall_req),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after posedge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    start = 1'b1; md_op = op; A = a; B = b;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step(); step(); step();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (stall_req !== 1'b0) begin bad++;
      $display("FAIL reset_stall got=%0b exp=0", stall_req); end
    total++; if (HI !== 32'd0) begin bad++;
      $display("FAIL reset_hi got=%h exp=0", HI); end
    total++; if (LO !== 32'd0) begin bad++;
      $display("FAIL reset_lo got=%h exp=0", LO); end
  endtask

  task automatic test_mult();
    int n;
    start = 1'b1; md_op = 2'b00; A = -32'sd3; B = 32'd7;
    #1;
    total++; if (stall_req !== 1'b1) begin bad++;
      $display("FAIL mult_stall_first got=%0b exp=1", stall_req); end
    step();
    start = 1'b0;
    total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++;
      $display("FAIL mult_hold got=%h_%h exp=0_0", HI, LO); end
    wait_done(n);
    total++; if (n != 5) begin bad++;
      $display("FAIL mult_busy_len got=%0d exp=5", n); end
    total++; if (HI !== 32'hFFFFFFFF) begin bad++;
      $display("FAIL mult_hi got=%h exp=ffffffff", HI); end
    total++; if (LO !== 32'hFFFFFFEB) begin bad++;
      $display("FAIL mult_lo got=%h exp=ffffffeb", LO); end
    issue(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_done(n);
    total++; if (HI !== 32'd0 || LO !== 32'd1) begin bad++;
      $display("FAIL mult_m1 got=%h_%h exp=0_1", HI, LO); end
  endtask

  task automatic test_div();
    int n;
    issue(2'b10, -32'sd7, 32'd2);
    total++; if (stall_req !== 1'b1) begin bad++;
      $display("FAIL div_stall got=%0b exp=1", stall_req); end
    wait_done(n);
    total++; if (n != 10) begin bad++;
      $display("FAIL div_busy_len got=%0d exp=10", n); end
    total++; if (LO !== 32'hFFFFFFFD) begin bad++;
      $display("FAIL div_lo got=%h exp=fffffffd", LO); end
    total++; if (HI !== 32'hFFFFFFFF) begin bad++;
      $display("FAIL div_hi got=%h exp=ffffffff", HI); end
    issue(2'b11, 32'hFFFFFFF9, 32'd2);
    wait_done(n);
    total++; if (n != 10) begin bad++;
      $display("FAIL divu_busy_len got=%0d exp=10", n); end
    total++; if (LO !== 32'h7FFFFFFC) begin bad++;
      $display("FAIL divu_lo got=%h exp=7ffffffc", LO); end
    total++; if (HI !== 32'd1) begin bad++;
      $display("FAIL divu_hi got=%h exp=1", HI); end
  endtask

  task automatic test_mtlo_divzero();
    int n;
    hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'h1234;
    step();
    hilo_we = 1'b0;
    total++; if (LO !== 32'h1234) begin bad++;
      $display("FAIL mtlo got=%h exp=1234", LO); end
    total++; if (HI !== 32'd1) begin bad++;
      $display("FAIL mtlo_hi_kept got=%h exp=1", HI); end
    issue(2'b11, 32'd100, 32'd0);
    wait_done(n);
    total++; if (n != 10) begin bad++;
      $display("FAIL div0_busy_len got=%0d exp=10", n); end
    total++; if (HI !== 32'd1 || LO !== 32'h1234) begin bad++;
      $display("FAIL div0_hilo got=%h_%h exp=1_1234", HI, LO); end
  endtask

  task automatic test_back_to_back();
    int n;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    n = (busy === 1'b1) ? 1 : 0;
    start = 1'b1; md_op = 2'b01; A = 32'd1; B = 32'd1;
    hilo_we = 1'b1; hilo_sel = 1'b1; wdata = 32'hDEAD;
    step();
    start = 1'b0; hilo_we = 1'b0;
    total++; if (stall_req !== 1'b1) begin bad++;
      $display("FAIL b2b_stall got=%0b exp=1", stall_req); end
    total++; if (HI !== 32'd1) begin bad++;
      $display("FAIL b2b_mthi_busy got=%h exp=1", HI); end
    begin
      int m;
      wait_done(m);
      n += m;
    end
    total++; if (n != 5) begin bad++;
      $display("FAIL b2b_busy_len got=%0d exp=5", n); end
    total++; if (HI !== 32'hFFFFFFFE) begin bad++;
      $display("FAIL b2b_hi got=%h exp=fffffffe", HI); end
    total++; if (LO !== 32'd1) begin bad++;
      $display("FAIL b2b_lo got=%h exp=1", LO); end
    total++; if (stall_req !== 1'b0) begin bad++;
      $display("FAIL b2b_stall_idle got=%0b exp=0", stall_req); end
  endtask

  task automatic test_start_and_we();
    int n;
    hilo_we = 1'b1; hilo_sel = 1'b0; wdata = 32'hAAAA;
    issue(2'b00, 32'd2, 32'd3);
    hilo_we = 1'b0;
    total++; if (LO !== 32'd1) begin bad++;
      $display("FAIL sw_we_ignored got=%h exp=1", LO); end
    wait_done(n);
    total++; if (n != 5) begin bad++;
      $display("FAIL sw_busy_len got=%0d exp=5", n); end
    total++; if (HI !== 32'd0 || LO !== 32'd6) begin bad++;
      $display("FAIL sw_result got=%h_%h exp=0_6", HI, LO); end
  endtask

  task automatic test_reset_mid();
    issue(2'b00, 32'd5, 32'd6);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rmid_busy got=%0b exp=0", busy); end
    total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++;
      $display("FAIL rmid_hilo got=%h_%h exp=0_0", HI, LO); end
    repeat (8) step();
    total++; if (busy !== 1'b0) begin bad++;
      $display("FAIL rmid_busy_late got=%0b exp=0", busy); end
    total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++;
      $display("FAIL rmid_late_write got=%h_%h exp=0_0", HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mtlo_divzero();
    test_back_to_back();
    test_start_and_we();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
